// File: rtl/satd_diff_buffer.sv
// satd_diff_buffer
//   Difference stage behind the SATD control FSM. For each original/reference pixel pair
//   it computes a signed residual. It collects the 16 residuals of a 4x4 block in a
//   ping-pong pair of banks. Each completed block is handed to the Hadamard stage over
//   a valid/ready handshake.
//
//   Optional feature: define SATD_DIFF_SAD_EN to add a running sum of |residual| per
//   block, presented on out_sad alongside out_diff. Without the macro out_sad is tied 0.
//
// Ports
//   clk, rst      system clock, synchronous active-high reset
//   ENABLE_DIFF   write enable from the control FSM
//   RESET_DIFF    synchronous clear of the write bank and write mask
//   COUNTER       entry index k = row*4+col; k==15 completes a block
//   orig_pixel    original pixel, unsigned
//   ref_pixel     reference/predicted pixel, unsigned
//   out_diff      block residuals, entry k at [k*DIFF_W +: DIFF_W], two's complement
//   out_valid     out_diff holds a complete block
//   out_ready     downstream accepts the block
//   out_sad       sum of absolute residuals of the presented block (0 if feature off)
//   overflow_err  sticky: a completed block was dropped because the read bank was busy
//   seq_err       sticky: a block completed with entries never written
module satd_diff_buffer #(
    parameter int unsigned PIXEL_W = 8,
    parameter int unsigned BLK_N   = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           ENABLE_DIFF,
    input  logic                           RESET_DIFF,
    input  logic [3:0]                     COUNTER,
    input  logic [PIXEL_W-1:0]             orig_pixel,
    input  logic [PIXEL_W-1:0]             ref_pixel,
    output logic [BLK_N*(PIXEL_W+1)-1:0]   out_diff,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [11:0]                    out_sad,
    output logic                           overflow_err,
    output logic                           seq_err
);

    localparam int unsigned DIFF_W = PIXEL_W + 1;
    localparam int unsigned SAD_W  = 12;

    // Two banks; wr_ptr_q selects the one being filled, the other is presented.
    logic [DIFF_W-1:0] bank_q [2][BLK_N];
    logic [DIFF_W-1:0] bank_d [2][BLK_N];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr;
    logic [BLK_N-1:0]  mask_q, mask_d;
    logic              out_valid_q, out_valid_d;
    logic              overflow_q, overflow_d;
    logic              seq_q, seq_d;

    logic [DIFF_W-1:0] diff;
    logic [BLK_N-1:0]  onehot;
    logic [BLK_N-1:0]  mask_new;
    logic              xfer;

    assign diff   = {1'b0, orig_pixel} - {1'b0, ref_pixel};
    assign rd_ptr = ~wr_ptr_q;
    assign xfer   = out_valid_q & out_ready;

`ifdef SATD_DIFF_SAD_EN
    logic [SAD_W-1:0] acc_q, acc_d;
    logic [SAD_W-1:0] out_sad_q, out_sad_d;

    function automatic logic [SAD_W-1:0] abs_ext(input logic [DIFF_W-1:0] v);
        logic [DIFF_W-1:0] m;
        m = v[DIFF_W-1] ? (~v + DIFF_W'(1)) : v;
        return SAD_W'(m);
    endfunction
`endif

    always_comb begin
        bank_d      = bank_q;
        mask_d      = mask_q;
        wr_ptr_d    = wr_ptr_q;
        out_valid_d = out_valid_q & ~xfer;
        overflow_d  = overflow_q;
        seq_d       = seq_q;
        onehot      = '0;
        onehot[COUNTER] = 1'b1;
        mask_new    = mask_q | onehot;
`ifdef SATD_DIFF_SAD_EN
        acc_d       = acc_q;
        out_sad_d   = out_sad_q;
`endif
        if (RESET_DIFF) begin
            // Clearing the write side beats a simultaneous write; read side untouched.
            for (int k = 0; k < BLK_N; k++) bank_d[wr_ptr_q][k] = '0;
            mask_d = '0;
`ifdef SATD_DIFF_SAD_EN
            acc_d = '0;
`endif
        end else if (ENABLE_DIFF) begin
            bank_d[wr_ptr_q][COUNTER] = diff;
            mask_d = mask_new;
`ifdef SATD_DIFF_SAD_EN
            // Rewrites replace the old contribution rather than adding to it.
            acc_d = acc_q - abs_ext(bank_q[wr_ptr_q][COUNTER]) + abs_ext(diff);
`endif
            if (COUNTER == 4'(BLK_N - 1)) begin
                if (mask_new != '1) seq_d = 1'b1;
                mask_d = '0;
                if (!out_valid_q || xfer) begin
                    // Swap: the old read bank becomes the fresh, cleared write bank.
                    wr_ptr_d    = ~wr_ptr_q;
                    for (int k = 0; k < BLK_N; k++) bank_d[rd_ptr][k] = '0;
                    out_valid_d = 1'b1;
`ifdef SATD_DIFF_SAD_EN
                    out_sad_d   = acc_d;
                    acc_d       = '0;
`endif
                end else begin
                    // Read bank still held: drop the completed block.
                    overflow_d = 1'b1;
                    for (int k = 0; k < BLK_N; k++) bank_d[wr_ptr_q][k] = '0;
`ifdef SATD_DIFF_SAD_EN
                    acc_d = '0;
`endif
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int k = 0; k < BLK_N; k++) bank_q[b][k] <= '0;
            end
            wr_ptr_q    <= 1'b0;
            mask_q      <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            seq_q       <= 1'b0;
`ifdef SATD_DIFF_SAD_EN
            acc_q       <= '0;
            out_sad_q   <= '0;
`endif
        end else begin
            for (int b = 0; b < 2; b++) begin
                for (int k = 0; k < BLK_N; k++) bank_q[b][k] <= bank_d[b][k];
            end
            wr_ptr_q    <= wr_ptr_d;
            mask_q      <= mask_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
            seq_q       <= seq_d;
`ifdef SATD_DIFF_SAD_EN
            acc_q       <= acc_d;
            out_sad_q   <= out_sad_d;
`endif
        end
    end

    always_comb begin
        out_diff = '0;
        for (int k = 0; k < BLK_N; k++) out_diff[k*DIFF_W +: DIFF_W] = bank_q[rd_ptr][k];
    end

    assign out_valid    = out_valid_q;
    assign overflow_err = overflow_q;
    assign seq_err      = seq_q;

`ifdef SATD_DIFF_SAD_EN
    assign out_sad = out_sad_q;
`else
    assign out_sad = '0;
`endif

endmodule

// File: tb/tb_satd_diff_buffer.sv
// Scoreboard bench for satd_diff_buffer: stimulus pushes expected blocks, a negedge
// monitor pops and compares whenever a transfer (out_valid & out_ready) is presented.
module tb_satd_diff_buffer;

    typedef struct {
        logic [143:0] diff;
        logic [11:0]  sad;
    } blk_t;

    logic         clk;
    logic         rst;
    logic         en;
    logic         rdiff;
    logic [3:0]   cnt;
    logic [7:0]   orig;
    logic [7:0]   refp;
    logic [143:0] out_diff;
    logic         out_valid;
    logic         out_ready;
    logic [11:0]  out_sad;
    logic         overflow_err;
    logic         seq_err;

    int   total = 0;
    int   bad   = 0;
    blk_t exp_q[$];

    satd_diff_buffer dut (
        .clk          (clk),
        .rst          (rst),
        .ENABLE_DIFF  (en),
        .RESET_DIFF   (rdiff),
        .COUNTER      (cnt),
        .orig_pixel   (orig),
        .ref_pixel    (refp),
        .out_diff     (out_diff),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sad      (out_sad),
        .overflow_err (overflow_err),
        .seq_err      (seq_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [143:0] act, input logic [143:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    function automatic logic [7:0] po(input int pat, input int k);
        case (pat)
            0: return 8'(100 + k);
            1: return 8'd0;
            2: return 8'(3 * k);
            3: return 8'd200;
            4: return 8'd50;
            5: return 8'(255 - k);
            default: return 8'(10 * k);
        endcase
    endfunction

    function automatic logic [7:0] pr(input int pat, input int k);
        case (pat)
            0: return 8'd90;
            1: return 8'd255;
            2: return 8'd20;
            3: return 8'(k);
            4: return 8'(60 + 2 * k);
            5: return 8'(5 * k);
            default: return 8'd40;
        endcase
    endfunction

    function automatic blk_t make_exp(input int pat, input logic [15:0] m);
        blk_t b;
        int s;
        logic [8:0] d;
        b.diff = '0;
        s = 0;
        for (int k = 0; k < 16; k++) begin
            if (m[k]) begin
                d = {1'b0, po(pat, k)} - {1'b0, pr(pat, k)};
                b.diff[k*9 +: 9] = d;
                s += d[8] ? (512 - int'(d)) : int'(d);
            end
        end
`ifdef SATD_DIFF_SAD_EN
        b.sad = 12'(s);
`else
        b.sad = 12'd0;
`endif
        return b;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic write_px(input int k, input logic [7:0] o, input logic [7:0] r);
        en   = 1'b1;
        cnt  = 4'(k);
        orig = o;
        refp = r;
        @(posedge clk);
        #1 en = 1'b0;
    endtask

    task automatic write_pat(input int pat, input int k0, input int k1);
        for (int k = k0; k <= k1; k++) write_px(k, po(pat, k), pr(pat, k));
    endtask

    task automatic one_cycle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare on every cycle a transfer is about to happen.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_block", 144'(out_valid), 144'd0);
            end else begin
                blk_t e;
                e = exp_q.pop_front();
                chk("block_diff", out_diff, e.diff);
                chk("block_sad", 144'(out_sad), 144'(e.sad));
            end
        end
    end

    initial begin
        int n;
        rst = 1'b1; en = 1'b0; rdiff = 1'b0; cnt = '0; orig = '0; refp = '0; out_ready = 1'b0;
        do_reset();
        chk("rst_valid", 144'(out_valid), 144'd0);
        chk("rst_ovf", 144'(overflow_err), 144'd0);
        chk("rst_seq", 144'(seq_err), 144'd0);
        chk("rst_diff", out_diff, 144'd0);
        chk("rst_sad", 144'(out_sad), 144'd0);

        // Ramp block: entries 10+k, latency one clock after k=15.
        write_pat(0, 0, 15);
        chk("t1_valid", 144'(out_valid), 144'd1);
        chk("t1_seq", 144'(seq_err), 144'd0);
        chk("t1_e0", 144'(out_diff[8:0]), 144'd10);
        chk("t1_e15", 144'(out_diff[143:135]), 144'd25);
`ifdef SATD_DIFF_SAD_EN
        chk("t1_sad", 144'(out_sad), 144'd280);
`endif
        exp_q.push_back(make_exp(0, 16'hFFFF));
        out_ready = 1'b1;
        one_cycle();
        out_ready = 1'b0;
        chk("t1_drain", 144'(out_valid), 144'd0);

        // Most negative residual everywhere.
        out_ready = 1'b1;
        write_pat(1, 0, 15);
        chk("t2_e7", 144'(out_diff[71:63]), 144'h101);
`ifdef SATD_DIFF_SAD_EN
        chk("t2_sad", 144'(out_sad), 144'd4080);
`endif
        exp_q.push_back(make_exp(1, 16'hFFFF));
        one_cycle();
        out_ready = 1'b0;
        chk("t2_drain", 144'(out_valid), 144'd0);

        // Back-pressure across two blocks: second is dropped.
        write_pat(2, 0, 15);
        exp_q.push_back(make_exp(2, 16'hFFFF));
        write_pat(3, 0, 15);
        chk("t3_ovf", 144'(overflow_err), 144'd1);
        chk("t3_valid", 144'(out_valid), 144'd1);
        out_ready = 1'b1;
        one_cycle();
        out_ready = 1'b0;
        chk("t3_drain", 144'(out_valid), 144'd0);
        do_reset();

        // Transfer coincides with completion of the next block.
        write_pat(4, 0, 15);
        exp_q.push_back(make_exp(4, 16'hFFFF));
        write_pat(5, 0, 14);
        out_ready = 1'b1;
        write_px(15, po(5, 15), pr(5, 15));
        out_ready = 1'b0;
        exp_q.push_back(make_exp(5, 16'hFFFF));
        chk("t4_valid", 144'(out_valid), 144'd1);
        chk("t4_ovf", 144'(overflow_err), 144'd0);
        out_ready = 1'b1;
        one_cycle();
        out_ready = 1'b0;
        chk("t4_drain", 144'(out_valid), 144'd0);

        // RESET_DIFF mid-block: first half lost, seq_err raised.
        do_reset();
        out_ready = 1'b1;
        write_pat(6, 0, 7);
        rdiff = 1'b1;
        one_cycle();
        rdiff = 1'b0;
        write_pat(6, 8, 15);
        exp_q.push_back(make_exp(6, 16'hFF00));
        chk("t5_seq", 144'(seq_err), 144'd1);
        one_cycle();
        out_ready = 1'b0;

        // rst mid-block with a block pending: everything cleared, then normal operation.
        do_reset();
        write_pat(0, 0, 15);
        write_pat(1, 0, 8);
        rst = 1'b1;
        write_px(9, po(1, 9), pr(1, 9));
        rst = 1'b0;
        chk("t6_valid", 144'(out_valid), 144'd0);
        chk("t6_ovf", 144'(overflow_err), 144'd0);
        chk("t6_seq", 144'(seq_err), 144'd0);
        chk("t6_diff", out_diff, 144'd0);
        chk("t6_sad", 144'(out_sad), 144'd0);
        out_ready = 1'b1;
        write_pat(2, 0, 15);
        exp_q.push_back(make_exp(2, 16'hFFFF));
        chk("t6_seq2", 144'(seq_err), 144'd0);

        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            one_cycle();
            n++;
        end
        chk("queue_drained", 144'(exp_q.size()), 144'd0);
        one_cycle();
        chk("final_idle", 144'(out_valid), 144'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/satd_diff_buffer.md
Name: satd_diff_buffer

Overview:
- Difference stage directly downstream of the SATD control FSM.
- Consumes ENABLE_DIFF, RESET_DIFF and COUNTER, together with one original/reference pixel pair per cycle.
- Computes signed pixel differences and collects the 16 residuals of a 4x4 block into ping-pong banks.
- Presents each completed block to the Hadamard stage over a valid/ready handshake.

Parameters:
- PIXEL_W, 8, pixel width in bits; difference width DIFF_W = PIXEL_W+1 (derived, not overridable).
- BLK_N, 16, entries per block; fixed to 4x4, used only for readability.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- ENABLE_DIFF  in  1  write enable from control FSM
- RESET_DIFF  in  1  synchronous clear of the write side
- COUNTER  in  4  entry index, k = row*4+col
- orig_pixel  in  PIXEL_W  original pixel, unsigned
- ref_pixel  in  PIXEL_W  reference/predicted pixel, unsigned
- out_diff  out  BLK_N*DIFF_W  block residuals; entry k at [k*DIFF_W +: DIFF_W], two's complement
- out_valid  out  1  out_diff holds a complete block
- out_ready  in  1  Hadamard stage accepts the block
- out_sad  out  12  sum of absolute residuals (optional feature)
- overflow_err  out  1  sticky: a completed block was dropped
- seq_err  out  1  sticky: a block completed with missing entries

Behaviour:
- Reset (rst=1 at a clock edge):
  - out_valid=0, overflow_err=0, seq_err=0, out_diff=0, out_sad=0.
  - Both banks cleared, write mask cleared, write pointer = bank 0.
  - Reset has priority over every other input, including mid-block and while a block is pending.
- Difference: diff = {1'b0,orig_pixel} - {1'b0,ref_pixel}, DIFF_W signed, range -255..+255. No saturation.
- Write:
  - Occurs when ENABLE_DIFF=1 and RESET_DIFF=0.
  - Stores diff into write bank entry COUNTER and sets write_mask[COUNTER].
  - Re-writing the same index overwrites the entry, with no error.
- RESET_DIFF=1:
  - Clears the write bank contents and write_mask on the next edge.
  - The pending read bank and out_valid are untouched.
  - RESET_DIFF takes priority over a simultaneous write.
- Block completion: a write with COUNTER==15.
  - If write_mask (including this write) is not all ones, set seq_err. The block is still emitted; missing entries read 0.
  - If the read bank is free (out_valid=0, or transfer in this same cycle), swap banks. out_valid=1 and out_diff show the block on the next cycle (latency 1 clock from the index-15 write).
  - The new write bank and write_mask are cleared at the swap.
  - If the read bank is occupied and not transferring, the completed block is discarded and overflow_err is set. The write bank is cleared and mask reset; out_valid and out_diff are unchanged.
- Wrap-around: COUNTER 15->0 starts a new block in the fresh write bank with no bubble. Continuous streaming at 1 pixel/clk is sustained when out_ready is high at least once per 16 cycles.
- Output handshake:
  - Transfer occurs when out_valid & out_ready at a clock edge.
  - out_diff is stable while out_valid=1 and not transferred.
  - After a transfer with no simultaneous completion, out_valid=0 on the next cycle; out_diff holds its last value.
  - A transfer and a completion in the same cycle give out_valid=1 continuously with the new block, and no overflow.
- Output state machine: EMPTY (out_valid=0) -> FULL on completion; FULL -> EMPTY on transfer without completion; FULL -> FULL on transfer plus completion.
- Sticky errors clear only on rst.

Optional Feature:
- Macro: SATD_DIFF_SAD_EN.
- When defined:
  - A 12-bit accumulator sums |diff| for each write, and is cleared together with the write bank.
  - On swap, the total is registered to out_sad, aligned with out_valid/out_diff (maximum 16*255 = 4080).
  - Re-written entries: the accumulator subtracts the old |entry| and adds the new one.
- When undefined: the out_sad port remains and is driven constant 0; no accumulator logic exists.

Test Plan:
- rst, then 16 writes (k=0..15) with orig=100+k, ref=90 -> one cycle after the k=15 write, out_valid=1, entry k = 10+k, seq_err=0; with SAD_EN, out_sad = 280.
- orig=0, ref=255 on all 16 writes -> every entry = 9'h101 (-255); SAD_EN gives out_sad = 4080.
- out_ready=0 throughout two full blocks -> first block held unchanged, second dropped, overflow_err=1; then out_ready=1 -> transfer, out_valid=0.
- out_ready asserted exactly in the cycle of the second block's k=15 write -> out_valid stays 1, out_diff switches to block 2, overflow_err=0.
- Writes k=0..7, RESET_DIFF pulse, then k=8..15 -> block emitted with entries 0..7 = 0, seq_err=1.
- rst asserted at k=9 while a block is pending -> next cycle out_valid=0 and flags 0; a fresh 16-write block then completes normally.
